// File: rtl/proj2_pkg.sv
// Shared definitions for the Proj2 pipeline: default widths, ALU command encodings
// and the legal-command check used by the execute stage.
package proj2_pkg;

   localparam int DEFAULT_BITS  = 32;
   localparam int DEFAULT_CBITS = 4;
   localparam int DEFAULT_RBITS = 4;

   localparam logic [DEFAULT_CBITS-1:0] CMD_ADD  = 4'b0000;
   localparam logic [DEFAULT_CBITS-1:0] CMD_SUB  = 4'b0001;
   localparam logic [DEFAULT_CBITS-1:0] CMD_LT   = 4'b0100;
   localparam logic [DEFAULT_CBITS-1:0] CMD_LE   = 4'b0101;
   localparam logic [DEFAULT_CBITS-1:0] CMD_AND  = 4'b1000;
   localparam logic [DEFAULT_CBITS-1:0] CMD_OR   = 4'b1001;
   localparam logic [DEFAULT_CBITS-1:0] CMD_XOR  = 4'b1010;
   localparam logic [DEFAULT_CBITS-1:0] CMD_NAND = 4'b1100;
   localparam logic [DEFAULT_CBITS-1:0] CMD_NOR  = 4'b1101;
   localparam logic [DEFAULT_CBITS-1:0] CMD_NXOR = 4'b1110;

   function automatic logic is_legal_cmd(input logic [DEFAULT_CBITS-1:0] ctl);
      logic legal;
      case (ctl)
         CMD_ADD, CMD_SUB, CMD_LT, CMD_LE,
         CMD_AND, CMD_OR, CMD_XOR, CMD_NAND, CMD_NOR, CMD_NXOR: legal = 1'b1;
         default:                                              legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: arithmetic, signed compares and bitwise ops, zero latency.
// Undefined commands produce zero; legality is flagged by the caller.
module ALU
   import proj2_pkg::*;
#(
   parameter int BITS  = DEFAULT_BITS,
   parameter int CBITS = DEFAULT_CBITS
) (
   input  logic [CBITS-1:0] i_ctl,
   input  logic [BITS-1:0]  i_a,
   input  logic [BITS-1:0]  i_b,
   output logic [BITS-1:0]  o_result
);

   logic w_lt;
   logic w_eq;

   // Compares treat operands as two's-complement values.
   assign w_lt = $signed(i_a) < $signed(i_b);
   assign w_eq = (i_a == i_b);

   always_comb begin
      o_result = '0;
      case (i_ctl)
         CMD_ADD:  o_result = i_a + i_b;
         CMD_SUB:  o_result = i_a - i_b;
         CMD_LT:   o_result = {{(BITS-1){1'b0}}, w_lt};
         CMD_LE:   o_result = {{(BITS-1){1'b0}}, w_lt | w_eq};
         CMD_AND:  o_result = i_a & i_b;
         CMD_OR:   o_result = i_a | i_b;
         CMD_XOR:  o_result = i_a ^ i_b;
         CMD_NAND: o_result = ~(i_a & i_b);
         CMD_NOR:  o_result = ~(i_a | i_b);
         CMD_NXOR: o_result = ~(i_a ^ i_b);
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU and the EX/MEM register, latency 1 cycle.
// A full register with OUT_READY low holds its contents, drops IN_READY and counts stalls.
module ex_stage
   import proj2_pkg::*;
#(
   parameter int BITS  = DEFAULT_BITS,
   parameter int CBITS = DEFAULT_CBITS,
   parameter int RBITS = DEFAULT_RBITS
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [CBITS-1:0] IN_CTL,
   input  logic [RBITS-1:0] IN_RA,
   input  logic [RBITS-1:0] IN_RB,
   input  logic [BITS-1:0]  IN_AVAL,
   input  logic [BITS-1:0]  IN_BVAL,
   input  logic [BITS-1:0]  IN_IMM,
   input  logic             IN_USEIMM,
   input  logic [RBITS-1:0] IN_RD,
   input  logic             IN_WREN,
   input  logic             WB_VALID,
   input  logic             WB_WREN,
   input  logic [RBITS-1:0] WB_RD,
   input  logic [BITS-1:0]  WB_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [BITS-1:0]  OUT_RESULT,
   output logic [RBITS-1:0] OUT_RD,
   output logic             OUT_WREN,
   output logic             OUT_ILLEGAL,
   output logic [15:0]      STALLS
);

   logic             r_out_valid;
   logic [BITS-1:0]  r_out_result;
   logic [RBITS-1:0] r_out_rd;
   logic             r_out_wren;
   logic             r_out_illegal;
   logic [15:0]      r_stalls;

   logic             w_accept;
   logic             w_stall;
   logic             w_legal;
   logic [BITS-1:0]  w_op_a;
   logic [BITS-1:0]  w_op_b;
   logic [BITS-1:0]  w_alu_result;

   assign IN_READY = ~r_out_valid | OUT_READY;
   assign w_accept = IN_VALID & IN_READY;
   assign w_stall  = r_out_valid & ~OUT_READY;
   assign w_legal  = is_legal_cmd(IN_CTL);

   // EX/MEM forward outranks WB since it is the younger producer; it stays live while stalled.
   always_comb begin
      w_op_a = IN_AVAL;
      if (IN_RA == '0)
         w_op_a = '0;
      else if (r_out_valid && r_out_wren && r_out_rd == IN_RA)
         w_op_a = r_out_result;
      else if (WB_VALID && WB_WREN && WB_RD == IN_RA)
         w_op_a = WB_DATA;
   end

   always_comb begin
      w_op_b = IN_BVAL;
      if (IN_USEIMM)
         w_op_b = IN_IMM;
      else if (IN_RB == '0)
         w_op_b = '0;
      else if (r_out_valid && r_out_wren && r_out_rd == IN_RB)
         w_op_b = r_out_result;
      else if (WB_VALID && WB_WREN && WB_RD == IN_RB)
         w_op_b = WB_DATA;
   end

   ALU #(
      .BITS  (BITS),
      .CBITS (CBITS)
   ) u_alu (
      .i_ctl    (IN_CTL),
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .o_result (w_alu_result)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_rd      <= '0;
         r_out_wren    <= 1'b0;
         r_out_illegal <= 1'b0;
         r_stalls      <= '0;
      end else if (w_stall) begin
         if (r_stalls != 16'hFFFF)
            r_stalls <= r_stalls + 16'd1;
      end else if (w_accept) begin
         r_out_valid   <= 1'b1;
         r_out_result  <= w_legal ? w_alu_result : '0;
         r_out_rd      <= IN_RD;
         r_out_wren    <= IN_WREN & w_legal;
         r_out_illegal <= ~w_legal;
      end else begin
         r_out_valid   <= 1'b0;
      end
   end

   assign OUT_VALID   = r_out_valid;
   assign OUT_RESULT  = r_out_result;
   assign OUT_RD      = r_out_rd;
   assign OUT_WREN    = r_out_wren;
   assign OUT_ILLEGAL = r_out_illegal;
   assign STALLS      = r_stalls;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the Proj2 pipeline: accepts decoded instructions from decode over a valid/ready handshake and resolves operand A/B through a forwarding network. It drives the combinational ALU, instantiated inside this block, and registers the result, destination and write-enable into the EX/MEM pipeline register. That register feeds the memory/writeback stage. It also counts backpressure stall cycles for performance debug.

## Interface
- BITS, 32, data width
- CBITS, 4, ALU control width
- RBITS, 4, register index width; register 0 reads as zero
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  decode presents an instruction
- IN_READY  out  1  stage can accept this cycle
- IN_CTL  in  CBITS  ALU command
- IN_RA, IN_RB  in  RBITS  source register indices
- IN_AVAL, IN_BVAL  in  BITS  register-file read data for RA/RB
- IN_IMM  in  BITS  sign-extended immediate
- IN_USEIMM  in  1  operand B = IN_IMM instead of RB
- IN_RD  in  RBITS  destination index
- IN_WREN  in  1  instruction writes RD
- WB_VALID, WB_WREN  in  1  writeback stage is writing this cycle
- WB_RD  in  RBITS; WB_DATA  in  BITS  writeback destination and data
- OUT_VALID  out  1  EX/MEM register holds a result
- OUT_READY  in  1  downstream consumes this cycle
- OUT_RESULT  out  BITS; OUT_RD  out  RBITS; OUT_WREN  out  1
- OUT_ILLEGAL  out  1  registered: captured IN_CTL was not a defined command
- STALLS  out  16  saturating count of cycles with OUT_VALID & ~OUT_READY

## Operation
- IN_READY = ~OUT_VALID | OUT_READY (combinational). Accept = IN_VALID & IN_READY.
- Operand A select, first match wins:
  - RA==0 → 0.
  - OUT_VALID & OUT_WREN & OUT_RD==RA → OUT_RESULT (EX/MEM forward).
  - WB_VALID & WB_WREN & WB_RD==RA → WB_DATA.
  - Otherwise IN_AVAL.
- Operand B: IN_USEIMM → IN_IMM. Otherwise the same chain on RB with IN_BVAL.
- ALU commands, fixed encodings:
  - ADD 0000, SUB 0001, LT 0100, LE 0101
  - AND 1000, OR 1001, XOR 1010, NAND 1100, NOR 1101, NXOR 1110
- LT/LE return 0 or 1 in bit 0, upper bits zero. Add/sub wrap modulo 2^BITS; no overflow flag.
- Undefined IN_CTL on accept: OUT_RESULT = 0, OUT_WREN = 0, OUT_ILLEGAL = 1. The instruction still flows (OUT_VALID = 1).
- EX/MEM register states:
  - EMPTY (OUT_VALID=0): accept → FULL.
  - FULL with OUT_READY & accept: reload the register, stay FULL.
  - FULL with OUT_READY & ~accept: → EMPTY.
  - FULL with ~OUT_READY: hold all OUT_* unchanged; IN_READY = 0.
- STALLS increments on every FULL & ~OUT_READY cycle and saturates at 16'hFFFF.

## Timing
- Latency 1: an instruction accepted at edge N appears on OUT_* after edge N.
- Throughput 1/cycle when OUT_READY is held high. Dependent back-to-back instructions need no bubble because of the EX/MEM forward.
- Forwarding is combinational within the accept cycle. WB and EX/MEM forwarding can match in the same cycle; EX/MEM wins.
- When stalled, OUT_RESULT is stable. Forwarding from it still applies to the instruction waiting at IN_*, which re-evaluates every cycle until it is accepted.
- RESET (asynchronous, any cycle, including mid-stall) clears:
  - OUT_VALID, OUT_RESULT, OUT_RD, OUT_WREN, OUT_ILLEGAL = 0
  - STALLS = 0
  - An in-flight instruction is discarded.
- IN_READY is 1 while RESET is deasserted and the register is empty, including the first cycle after reset release.

## Structure
- Shared package `proj2_pkg`: CMD_* encodings, BITS/CBITS/RBITS defaults, and a function is_legal_cmd(ctl).
- One sub-module: the existing combinational `ALU`, instantiated once and parameterised from the package.
- Forwarding muxes and the pipeline register live in ex_stage. Do not split them further.

## Test plan
- Reset then ADD, RA=1 (IN_AVAL=5), RB=2 (IN_BVAL=7) → next cycle OUT_VALID=1, OUT_RESULT=12.
- Back-to-back:
  - Instruction 1: SUB r3 = 10−3.
  - Instruction 2: ADD r4 = r3+r3, with stale IN_AVAL=IN_BVAL=99.
  - Required: OUT_RESULT=7 then 14.
- Forward priority: EX/MEM holds r5=1 and WB writes r5=2 in the same cycle; ADD r5+imm 0 → result 1.
- r0 suppression: OUT_RD=0 with OUT_WREN=1 and result 0xDEAD; next instruction reads RA=0 → operand A is 0, not 0xDEAD.
- Backpressure: OUT_READY=0 for 3 cycles with IN_VALID held.
  - Required: OUT_* frozen, IN_READY=0, STALLS=3.
  - On release, the next instruction is accepted in that same cycle.
- Illegal IN_CTL=0111 → OUT_ILLEGAL=1, OUT_WREN=0, OUT_RESULT=0.
- Asynchronous RESET pulsed mid-stall → all outputs 0 immediately, STALLS=0.
